// File: rtl/lowpass_cascade_pkg.sv
// Shared constants and helpers for the lowpass_cascade IIR filter chain.
// Optional feature macro used by this slice: LOWPASS_CASCADE_PRELOAD_EN.
package lowpass_cascade_pkg;

    localparam int DATA_W_DEF  = 28;
    localparam int FRAC_W_DEF  = 16;
    localparam int STATE_W_DEF = DATA_W_DEF + FRAC_W_DEF;

    // Effective active stage count: 0 behaves as 1, oversize requests clamp to the physical depth.
    function automatic int eff_stage_count(input int sel, input int stages);
        if (sel <= 0) begin
            return 1;
        end else if (sel > stages) begin
            return stages;
        end else begin
            return sel;
        end
    endfunction

endpackage

// File: rtl/lowpass_stage.sv
// One first-order IIR stage: y <= y + ((x - y) >>> tc), with valid tracking.
// With LOWPASS_CASCADE_PRELOAD_EN, the first valid sample after reset/clear loads the state directly.
module lowpass_stage
    import lowpass_cascade_pkg::*;
#(
    parameter int SW   = STATE_W_DEF,
    parameter int TC_W = 5
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic                 clear_i,
    input  logic                 x_valid_i,
    input  logic signed [SW-1:0] x_i,
    input  logic [TC_W-1:0]      tc_i,
    output logic signed [SW-1:0] state_o,
    output logic                 valid_o
);

    logic signed [SW-1:0] state_q, state_d;
    logic                 valid_q, valid_d;
    logic signed [SW:0]   diff, incr, sum;
    logic                 unused_sum_msb;

    // One extra bit keeps the difference exact; a convex update never needs it in the result.
    always_comb begin
        diff = {x_i[SW-1], x_i} - {state_q[SW-1], state_q};
        incr = diff >>> tc_i;
        sum  = {state_q[SW-1], state_q} + incr;
    end

    assign unused_sum_msb = sum[SW];

`ifdef LOWPASS_CASCADE_PRELOAD_EN
    logic primed_q, primed_d;

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        primed_d = primed_q;
        if (clear_i) begin
            state_d  = '0;
            valid_d  = 1'b0;
            primed_d = 1'b0;
        end else if (enable_i) begin
            if (x_valid_i) begin
                state_d  = primed_q ? sum[SW-1:0] : x_i;
                valid_d  = 1'b1;
                primed_d = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            primed_q <= 1'b0;
        end else begin
            primed_q <= primed_d;
        end
    end
`else
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        if (clear_i) begin
            state_d = '0;
            valid_d = 1'b0;
        end else if (enable_i) begin
            if (x_valid_i) begin
                state_d = sum[SW-1:0];
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
        end
    end

    assign state_o = state_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/lowpass_cascade.sv
// Cascade of STAGES IIR lowpass stages with a shared time-constant shadow and a selectable output tap.
// Optional startup preload of each stage is enabled by defining LOWPASS_CASCADE_PRELOAD_EN.
module lowpass_cascade
    import lowpass_cascade_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int STAGES   = 4,
    parameter int FRAC_W   = FRAC_W_DEF,
    parameter int TC_W     = 5,
    parameter int TC_RESET = 4,
    localparam int SEL_W   = $clog2(STAGES) + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] signal_in,
    input  logic [TC_W-1:0]          time_constant,
    input  logic                     tc_load,
    input  logic [SEL_W-1:0]         stage_sel,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] signal_out
);

    localparam int SW = DATA_W + FRAC_W;

    logic [TC_W-1:0] tc_q, tc_d;

    // The shadow is written even while the chain is stalled, and clear leaves it alone.
    always_comb begin
        tc_d = tc_q;
        if (tc_load) begin
            tc_d = time_constant;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tc_q <= TC_W'(TC_RESET);
        end else begin
            tc_q <= tc_d;
        end
    end

    logic signed [SW-1:0] st  [STAGES];
    logic                 vld [STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic signed [SW-1:0] x_k;
        logic                 xv_k;

        if (k == 0) begin : g_first
            assign x_k  = {signal_in, {FRAC_W{1'b0}}};
            assign xv_k = in_valid;
        end else begin : g_next
            assign x_k  = st[k-1];
            assign xv_k = vld[k-1];
        end

        lowpass_stage #(
            .SW   (SW),
            .TC_W (TC_W)
        ) u_stage (
            .clk_i     (clk),
            .reset_i   (reset),
            .enable_i  (enable),
            .clear_i   (clear),
            .x_valid_i (xv_k),
            .x_i       (x_k),
            .tc_i      (tc_q),
            .state_o   (st[k]),
            .valid_o   (vld[k])
        );
    end

    int                   tap_idx;
    logic signed [SW-1:0] tap_state;
    logic                 tap_valid;
    logic [FRAC_W-1:0]    unused_tap_frac;

    always_comb begin
        tap_idx   = eff_stage_count(32'(stage_sel), STAGES) - 1;
        tap_state = st[0];
        tap_valid = vld[0];
        for (int k = 0; k < STAGES; k++) begin
            if (k == tap_idx) begin
                tap_state = st[k];
                tap_valid = vld[k];
            end
        end
    end

    // Dropping the guard bits of a two's-complement value is a floor shift.
    assign signal_out      = tap_state[SW-1:FRAC_W];
    assign unused_tap_frac = tap_state[FRAC_W-1:0];
    assign out_valid       = tap_valid;

endmodule
